uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares the single UART transmitter (`tx_data`/`new_tx_data`/`tx_busy` port of the serial TX) between several byte-stream requesters, such as the message printer and a keyboard echo path. Grants are per message, not per byte: a granted requester keeps the transmitter until it sends a byte flagged `last`, drops `req`, or hits the length limit. Arbitration is round-robin across requesters, and the block enforces the TX busy handshake so no byte is lost.

## Interface
- `NUM_REQ`, default 2: number of requesters (2..8).
- `MAX_LEN`, default 16: maximum bytes per grant before forced release.
- `clk`  in  1: system clock.
- `rst`  in  1: reset; asynchronous, active-low (0 = reset).
- `req`  in  `NUM_REQ`: per-requester request, held high for the whole message.
- `byte_valid`  in  `NUM_REQ`: requester i presents a byte on its data slice.
- `byte_last`  in  `NUM_REQ`: the presented byte is the last of the message.
- `byte_data`  in  `8*NUM_REQ`: byte of requester i is on bits [8i+7:8i].
- `byte_ack`  out  `NUM_REQ`: one-cycle pulse; the presented byte was consumed.
- `grant`  out  `NUM_REQ`: one-hot current owner; all zero when idle.
- `tx_data`  out  8: byte to the serial TX.
- `new_tx_data`  out  1: one-cycle strobe to the serial TX.
- `tx_busy`  in  1: serial TX busy. Rises the cycle after `new_tx_data`.
- `msg_done`  out  1: one-cycle pulse when a grant ends normally (`last` sent).
- `len_err`  out  1: one-cycle pulse when a grant is force-released at `MAX_LEN`.

## Operation
- FSM states:
  - IDLE: `grant`=0. If any `req` is high, pick the first requester after `last_owner` in round-robin order, set `grant` and `last_owner`, clear `byte_cnt`, then go to SEND.
  - SEND:
    - If `req[g]`=0, go to RELEASE. No `msg_done`.
    - Else if `byte_valid[g]` && !`tx_busy`: register `tx_data`=`byte_data[g]`, pulse `new_tx_data` and `byte_ack[g]` together, increment `byte_cnt`, latch `last` = `byte_last[g]`, then go to HOLD.
  - HOLD: exactly 1 cycle, with `tx_busy` ignored. Then:
    - if `last` was latched, go to RELEASE with `msg_done` pending;
    - else if `byte_cnt`==`MAX_LEN`, go to RELEASE with `len_err` pending;
    - else go to SEND.
  - RELEASE: wait for `tx_busy`=0. Then pulse the pending `msg_done` or `len_err`, clear `grant`, and go to IDLE.
- `byte_cnt` width is clog2(`MAX_LEN`+1). It never wraps, because release happens at `MAX_LEN`.
- A byte completing with `last` at exactly `MAX_LEN` reports `msg_done` only, not `len_err`.
- Non-granted requesters never see `byte_ack`. Their `byte_valid` is ignored.
- Reset, asynchronous at any point:
  - all outputs go to 0, the state goes to IDLE, `byte_cnt` goes to 0;
  - `last_owner` goes to `NUM_REQ`-1, so requester 0 wins first;
  - a byte in flight in the serial TX is not recalled.

## Timing
- IDLE with `req` high in cycle N → `grant` high in cycle N+1.
- In SEND, `byte_valid` && !`tx_busy` in cycle N → `new_tx_data`, `byte_ack`, and a stable `tx_data` in cycle N+1.
  - `tx_data` holds its value until the next strobe.
- Minimum spacing between strobes is 2 cycles (SEND→HOLD→SEND). Real spacing is set by the `tx_busy` frame length.
- Simultaneous requests are resolved by the round-robin pointer only. No fixed priority.
- A requester that drops `req` and raises it in the same cycle the grant is released re-enters normal round-robin: after its own grant it ranks last.
- `msg_done` and `len_err` never assert in the same cycle.
- `len_err` at most once per grant.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (IDLE, SEND, HOLD, RELEASE);
  - the byte width constant (8);
  - a function for one-hot index to binary.
- One sub-module, `rr_pick`: combinational round-robin selector over `req` and `last_owner`, returning a one-hot result and its index.
- The rest lives in `uart_tx_arbiter`: the FSM, counter, output registers, and data mux.

## Test plan
- Reset mid-message: assert `rst`=0 while in HOLD → all outputs 0 immediately; after release, with both `req` high, `grant`=01.
- Single message: req0 sends 0x41, 0x42, 0x43 (last on 0x43), with the bench TX holding busy 10 cycles per byte → exactly 3 `new_tx_data` pulses carrying 0x41/0x42/0x43 in order, then `msg_done` once, then `grant`=00.
- Round-robin: `req`=11 held, each requester sends 2-byte messages → grants alternate 01, 10, 01, 10; bytes never interleave within a message.
- Busy handshake: `byte_valid` held high while `tx_busy`=1 for 20 cycles → no strobe until the cycle after `tx_busy` falls; no strobe in any HOLD cycle.
- Length limit: `MAX_LEN`=4, req1 sends 6 bytes without last → 4 strobes, `len_err` pulse, `grant` cleared; remaining bytes sent only after a re-grant.
- Abort: req0 drops `req` after 2 of 5 bytes → no further strobes for req0, no `msg_done`; a pending req1 is granted after `tx_busy` clears.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, byte width and
// a one-hot to binary index helper.
package uart_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned MAX_REQ = 8;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StHold,
        StRelease
    } arb_state_e;

    // OR-reduction form is exact for one-hot inputs and yields 0 for all-zero.
    function automatic logic [2:0] onehot_to_bin(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < int'(MAX_REQ); i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first active request after last_owner,
// returned both as one-hot and as a binary index.
module rr_pick
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   pick_idx,
    output logic               any
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            cand = IDX_W'((int'(last_owner) + k) % int'(NUM_REQ));
            if (!found && req[cand]) begin
                pick[cand] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign pick_idx = IDX_W'(onehot_to_bin(MAX_REQ'(pick)));
    assign any      = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Per-message round-robin arbiter in front of a single UART transmitter; enforces
// the tx_busy handshake and a per-grant byte limit.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned MAX_LEN = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        byte_valid,
    input  logic [NUM_REQ-1:0]        byte_last,
    input  logic [BYTE_W*NUM_REQ-1:0] byte_data,
    output logic [NUM_REQ-1:0]        byte_ack,
    output logic [NUM_REQ-1:0]        grant,
    output logic [BYTE_W-1:0]         tx_data,
    output logic                      new_tx_data,
    input  logic                      tx_busy,
    output logic                      msg_done,
    output logic                      len_err
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic               done_pend_q, done_pend_d;
    logic               len_pend_q, len_pend_d;
    logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
    logic               new_tx_q, new_tx_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               msg_done_q, msg_done_d;
    logic               len_err_q, len_err_d;

    logic [NUM_REQ-1:0] pick;
    logic [IDX_W-1:0]   pick_idx;
    logic               req_any;
    logic [BYTE_W-1:0]  data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign data_arr[i] = byte_data[i*BYTE_W +: BYTE_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (req),
        .last_owner (owner_q),
        .pick       (pick),
        .pick_idx   (pick_idx),
        .any        (req_any)
    );

    // owner_q doubles as the round-robin pointer and the mux select while granted.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        done_pend_d = done_pend_q;
        len_pend_d  = len_pend_q;
        tx_data_d   = tx_data_q;
        new_tx_d    = 1'b0;
        ack_d       = '0;
        msg_done_d  = 1'b0;
        len_err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    grant_d     = pick;
                    owner_d     = pick_idx;
                    cnt_d       = '0;
                    last_d      = 1'b0;
                    done_pend_d = 1'b0;
                    len_pend_d  = 1'b0;
                    state_d     = StSend;
                end
            end
            StSend: begin
                if (!req[owner_q]) begin
                    state_d = StRelease;
                end else if (byte_valid[owner_q] && !tx_busy) begin
                    tx_data_d = data_arr[owner_q];
                    new_tx_d  = 1'b1;
                    ack_d     = grant_q;
                    cnt_d     = cnt_q + CNT_W'(1);
                    last_d    = byte_last[owner_q];
                    state_d   = StHold;
                end
            end
            // One dead cycle so the TX has time to raise tx_busy for the new byte.
            StHold: begin
                if (last_q) begin
                    done_pend_d = 1'b1;
                    state_d     = StRelease;
                end else if (cnt_q == CNT_W'(MAX_LEN)) begin
                    len_pend_d = 1'b1;
                    state_d    = StRelease;
                end else begin
                    state_d = StSend;
                end
            end
            StRelease: begin
                if (!tx_busy) begin
                    msg_done_d  = done_pend_q;
                    len_err_d   = len_pend_q;
                    done_pend_d = 1'b0;
                    len_pend_d  = 1'b0;
                    grant_d     = '0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            owner_q     <= IDX_W'(NUM_REQ - 1);
            cnt_q       <= '0;
            last_q      <= 1'b0;
            done_pend_q <= 1'b0;
            len_pend_q  <= 1'b0;
            tx_data_q   <= '0;
            new_tx_q    <= 1'b0;
            ack_q       <= '0;
            msg_done_q  <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            done_pend_q <= done_pend_d;
            len_pend_q  <= len_pend_d;
            tx_data_q   <= tx_data_d;
            new_tx_q    <= new_tx_d;
            ack_q       <= ack_d;
            msg_done_q  <= msg_done_d;
            len_err_q   <= len_err_d;
        end
    end

    assign grant       = grant_q;
    assign byte_ack    = ack_q;
    assign tx_data     = tx_data_q;
    assign new_tx_data = new_tx_q;
    assign msg_done    = msg_done_q;
    assign len_err     = len_err_q;

endmodule
